// File: rtl/prescaled_updown_counter.sv
// -----------------------------------------------------------------------------
// prescaled_updown_counter
//
// Purpose:
//   Prescaled modulo up/down counter. A prescaler divides clk by PRESCALE; on
//   each prescaler tick the CNT_W-bit count steps up or down modulo MODULUS.
//   Supports enable/pause, synchronous load (clamped to MODULUS-1) and a
//   terminal-count pulse that marks a wrapping step.
//
// Optional feature:
//   COUNTER_SAT_EN - when defined, count saturates at the ends of its range
//                    instead of wrapping. A blocked step still pulses tick and
//                    tc together.
//
// Parameters:
//   CNT_W     width of count (default 8)
//   MODULUS   count range 0..MODULUS-1, 2..2**CNT_W (default 256)
//   PRESCALE  enabled clk cycles per count step, >= 1 (default 50000000)
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous, active-high reset
//   en        in   1 = prescaler runs; 0 = prescaler and count hold
//   up_dn     in   1 = count up, 0 = count down (used on step cycles only)
//   load      in   synchronous load strobe (overrides en and stepping)
//   load_val  in   value loaded on load, clamped to MODULUS-1
//   count     out  current count, registered
//   tick      out  one-cycle pulse, high when a new stepped count is visible
//   tc        out  one-cycle pulse, high with tick when the step wrapped
//                  (or was blocked in saturating mode)
//
// Priority on each edge: reset > load > step > hold.
// -----------------------------------------------------------------------------
module prescaled_updown_counter #(
  parameter int CNT_W    = 8,
  parameter int MODULUS  = 256,
  parameter int PRESCALE = 50000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             tick,
  output logic             tc
);

  // A one-bit prescaler is kept even for PRESCALE=1; it then sits at zero and
  // every enabled edge is a step.
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MODULUS - 1);
  // MODULUS may equal 2**CNT_W, so the load-range compare needs one extra bit.
  localparam logic [CNT_W:0]   MOD_EXT = (CNT_W + 1)'(MODULUS);

  logic [PS_W-1:0]  ps_q, ps_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             tc_q, tc_d;

  logic             step;
  logic             at_top;
  logic             at_bot;
  logic [CNT_W-1:0] load_clamped;

  always_comb begin
    step         = en && (ps_q == PS_LAST);
    at_top       = (count_q == MAX_CNT);
    at_bot       = (count_q == '0);
    load_clamped = ({1'b0, load_val} < MOD_EXT) ? load_val : MAX_CNT;

    ps_d    = ps_q;
    count_d = count_q;
    tick_d  = 1'b0;
    tc_d    = 1'b0;

    if (load) begin
      // Load restarts the period so the next step is a full PRESCALE away.
      count_d = load_clamped;
      ps_d    = '0;
    end else if (step) begin
      ps_d   = '0;
      tick_d = 1'b1;
      if (up_dn) begin
        if (at_top) begin
`ifdef COUNTER_SAT_EN
          count_d = count_q;
`else
          count_d = '0;
`endif
          tc_d = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end else begin
        if (at_bot) begin
`ifdef COUNTER_SAT_EN
          count_d = count_q;
`else
          count_d = MAX_CNT;
`endif
          tc_d = 1'b1;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
    end else if (en) begin
      ps_d = ps_q + PS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ps_q    <= '0;
      count_q <= '0;
      tick_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      ps_q    <= ps_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign tc    = tc_q;

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_prescaled_updown_counter
//
// Directed bench for prescaled_updown_counter with CNT_W=4, MODULUS=10.
// dut4 uses PRESCALE=4, dut1 uses PRESCALE=1. Expected values are written
// out by hand for each edge. COUNTER_SAT_EN selects saturating expectations.
// -----------------------------------------------------------------------------
module tb_prescaled_updown_counter;

  localparam int CNT_W   = 4;
  localparam int MODULUS = 10;

  // clock / reset
  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // PRESCALE=4 instance
  logic             reset;
  logic             en;
  logic             up_dn;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] count;
  logic             tick;
  logic             tc;

  // PRESCALE=1 instance
  logic             reset1;
  logic             en1;
  logic             up_dn1;
  logic             load1;
  logic [CNT_W-1:0] load_val1;
  logic [CNT_W-1:0] count1;
  logic             tick1;
  logic             tc1;

  prescaled_updown_counter #(
    .CNT_W(CNT_W), .MODULUS(MODULUS), .PRESCALE(4)
  ) dut4 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count(count), .tick(tick), .tc(tc)
  );

  prescaled_updown_counter #(
    .CNT_W(CNT_W), .MODULUS(MODULUS), .PRESCALE(1)
  ) dut1 (
    .clk(clk), .reset(reset1), .en(en1), .up_dn(up_dn1), .load(load1),
    .load_val(load_val1), .count(count1), .tick(tick1), .tc(tc1)
  );

  int checks;
  int errors;

  // checking task
  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) edge_wait();
  endtask

  task automatic check_out(input string tag, input int c, input int tk, input int t);
    check_val({tag, "_count"}, int'(count), c);
    check_val({tag, "_tick"},  int'(tick),  tk);
    check_val({tag, "_tc"},    int'(tc),    t);
  endtask

  task automatic do_load(input int v);
    load     = 1'b1;
    load_val = CNT_W'(v);
    edge_wait();
    load     = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    en        = 1'b0;
    up_dn     = 1'b1;
    load      = 1'b0;
    load_val  = '0;
    reset1    = 1'b1;
    en1       = 1'b0;
    up_dn1    = 1'b1;
    load1     = 1'b0;
    load_val1 = '0;

    // 1. reset, then basic up stepping every 4 edges
    edges(2);
    check_out("rst", 0, 0, 0);
    reset = 1'b0;
    en    = 1'b1;
    up_dn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      edge_wait();
      check_out("basic", i / 4, (i % 4 == 0) ? 1 : 0, 0);
    end

`ifndef COUNTER_SAT_EN
    // 2. up wrap 9 -> 0, then down wrap 0 -> 9
    do_load(9);
    check_out("ld9", 9, 0, 0);
    edges(3);
    check_out("upwrap_pre", 9, 0, 0);
    edge_wait();
    check_out("upwrap", 0, 1, 1);
    edge_wait();
    check_out("upwrap_post", 0, 0, 0);
    do_load(0);
    check_out("ld0", 0, 0, 0);
    up_dn = 1'b0;
    edges(4);
    check_out("dnwrap", 9, 1, 1);
`else
    // 6. saturating: blocked steps at both ends, then resume
    do_load(9);
    check_out("ld9", 9, 0, 0);
    up_dn = 1'b1;
    edges(4);
    check_out("sat_up1", 9, 1, 1);
    edges(4);
    check_out("sat_up2", 9, 1, 1);
    do_load(0);
    up_dn = 1'b0;
    edges(4);
    check_out("sat_dn", 0, 1, 1);
    up_dn = 1'b1;
    edges(3);
    check_out("sat_resume_pre", 0, 0, 0);
    edge_wait();
    check_out("sat_resume", 1, 1, 0);
`endif

    // 3. load mid-period restarts the period; out-of-range load clamps
    up_dn = 1'b1;
    do_load(0);
    edges(2);
    do_load(7);
    check_out("ld7", 7, 0, 0);
    edges(3);
    check_out("ld7_pre", 7, 0, 0);
    edge_wait();
    check_out("ld7_step", 8, 1, 0);
    do_load(10);
    check_out("ld10_clamp", 9, 0, 0);
    do_load(12);
    check_out("ld12_clamp", 9, 0, 0);

    // 4. pause after 2 enabled edges, resume finishes the period
    up_dn = 1'b0;
    edges(2);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      edge_wait();
      check_out("pause", 9, 0, 0);
    end
    en = 1'b1;
    edge_wait();
    check_out("resume1", 9, 0, 0);
    edge_wait();
    check_out("resume2", 8, 1, 0);

    // 5. reset on what would be a step edge discards the step and prescaler
    do_load(5);
    up_dn = 1'b1;
    edges(3);
    check_out("pre_rst", 5, 0, 0);
    reset = 1'b1;
    edge_wait();
    check_out("mid_rst", 0, 0, 0);
    reset = 1'b0;
    edges(3);
    check_out("post_rst_pre", 0, 0, 0);
    edge_wait();
    check_out("post_rst_step", 1, 1, 0);
    en = 1'b0;

    // 5b. PRESCALE=1: step on every enabled edge
    check_val("p1_rst_count", int'(count1), 0);
    check_val("p1_rst_tick",  int'(tick1),  0);
    reset1 = 1'b0;
    en1    = 1'b1;
    up_dn1 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      edge_wait();
`ifdef COUNTER_SAT_EN
      check_val("p1_count", int'(count1), (k <= 9) ? k : 9);
      check_val("p1_tc",    int'(tc1),    (k >= 10) ? 1 : 0);
`else
      check_val("p1_count", int'(count1), k % 10);
      check_val("p1_tc",    int'(tc1),    (k == 10) ? 1 : 0);
`endif
      check_val("p1_tick",  int'(tick1),  1);
    end
    en1 = 1'b0;
    edge_wait();
    check_val("p1_pause_tick", int'(tick1), 0);
    check_val("p1_pause_tc",   int'(tc1),   0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prescaled_updown_counter.md
Name: prescaled_updown_counter

Overview:
Parametrised prescaled counter for board-level timing: a prescaler divides clk by PRESCALE, and each prescaler tick steps a CNT_W-bit modulo-MODULUS counter up or down. Supports enable/pause, synchronous load and a terminal-count pulse. Drives LED/7-seg display counters and slow event timers on the Spartan-3 boards.

Parameters:
CNT_W, 8, width of count output
MODULUS, 256, count range 0..MODULUS-1; legal range 2..2**CNT_W
PRESCALE, 50000000, clk cycles per count step; PRESCALE >= 1; prescaler width = max(1, clog2(PRESCALE))

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
en  in  1  1 = prescaler runs; 0 = prescaler and count hold
up_dn  in  1  1 = count up, 0 = count down; sampled on step cycle only
load  in  1  synchronous load strobe
load_val  in  CNT_W  value loaded on load
count  out  CNT_W  current count, registered
tick  out  1  registered one-cycle pulse, high in the cycle the new count value is first visible
tc  out  1  registered one-cycle pulse, high with tick when the step wrapped

Behaviour:
- Priority per edge: reset > load > step > hold.
- reset: count=0, prescaler=0, tick=0, tc=0. Reset mid-period discards prescaler progress.
- load (en ignored): count <= load_val if load_val < MODULUS, else MODULUS-1; prescaler <= 0; tick=0, tc=0. Next step is a full PRESCALE enabled cycles later.
- Prescaler counts 0..PRESCALE-1 on edges with en=1. Step cycle = edge where en=1 and prescaler==PRESCALE-1.
- Step cycle: prescaler <= 0, tick <= 1, count <= next, tc <= wrap flag. All other edges: tick <= 0, tc <= 0.
- Next, up: count==MODULUS-1 -> 0 with wrap; else count+1.
- Next, down: count==0 -> MODULUS-1 with wrap; else count-1.
- en=0: prescaler and count hold, tick/tc = 0. Resuming completes the remaining enabled cycles of the period.
- Step timing: after reset with en held 1, the first step lands on the PRESCALE-th edge; steps recur every PRESCALE edges.
- PRESCALE=1: a step occurs on every enabled edge; tick stays high continuously while en=1.
- up_dn changes between steps take effect at the next step only.
- Arithmetic is unsigned CNT_W bits. count never leaves 0..MODULUS-1.
- No combinational path from inputs to outputs.

Optional Feature:
Macro COUNTER_SAT_EN.
- Defined: saturating mode. An up step at MODULUS-1 or a down step at 0 leaves count unchanged; tick=1 and tc=1 on that step (blocked-step indication), repeating on every subsequent blocked step. Load and reset behaviour unchanged.
- Undefined: wrap mode as described in Behaviour.

Test Plan:
Bench parameters: CNT_W=4, MODULUS=10, PRESCALE=4.
1. Basic step: reset for 2 cycles, then en=1, up_dn=1 -> tick pulses on edges 4, 8, 12 after release; count=1, 2, 3; tc stays 0.
2. Up wrap and down wrap: load 9, up -> after 4 enabled edges count=0 with tick=1, tc=1 in the same cycle. Load 0, down -> count=9, tc=1.
3. Load mid-period and clamp: 2 edges into a period, load=1, load_val=7 -> count=7, next step 4 edges later gives count=8. load_val=12 -> count=9.
4. Pause: en=0 after 2 enabled edges, held 10 cycles -> count unchanged, tick=0. Re-enable -> step after exactly 2 more edges.
5. Reset mid-operation and PRESCALE=1 instance: reset at count=5 -> count=0, no tick/tc. With PRESCALE=1 and en=1 -> count increments every edge, 9 wraps to 0 with tc.
6. COUNTER_SAT_EN defined: count=9, up -> count stays 9, tick=1, tc=1 on each step. count=0, down -> stays 0, tc=1. Switching to up resumes stepping to 1.
